tx_mac_lite_meta_merge: RTL
===========================

// Module: tx_mac_lite_meta_merge
// PURPOSE
//  Transmit-side counterpart of the RX MAC lite buffer output split: merges a per-frame MVB metadata stream with an
//  MFB frame data stream and re-attaches each frame's metadata to its SOF region, giving a single MFB stream with META.
//  Sits between the host-side TX pipeline (separate metadata and data paths) and the TX MAC lite frame logic.
//  Single clock domain; MFB output is registered.
// PARAMETERS
//  REGIONS      4         MFB regions per word; also the MVB items per word
//  REGION_SIZE  8         blocks per region
//  BLOCK_SIZE   8         items per block
//  ITEM_WIDTH   8         bits per item
//  META_WIDTH   16        bits of metadata per frame
//  FIFO_DEPTH   16        metadata FIFO entries; power of 2, >= 2*REGIONS
// PORTS  (DW = REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH, SW = log2(REGION_SIZE), EW = log2(REGION_SIZE*BLOCK_SIZE))
//  CLK             in   1               clock
//  RESET_N         in   1               reset, asynchronous, active-low
//  RX_MVB_DATA     in   REGIONS*META_WIDTH   per-item frame metadata
//  RX_MVB_VLD      in   REGIONS         item valid
//  RX_MVB_SRC_RDY  in   1               MVB word valid
//  RX_MVB_DST_RDY  out  1               MVB word accepted
//  RX_MFB_DATA     in   DW              frame data
//  RX_MFB_SOF_POS  in   REGIONS*SW      SOF block position per region
//  RX_MFB_EOF_POS  in   REGIONS*EW      EOF item position per region
//  RX_MFB_SOF      in   REGIONS         SOF per region
//  RX_MFB_EOF      in   REGIONS         EOF per region
//  RX_MFB_SRC_RDY  in   1               MFB word valid
//  RX_MFB_DST_RDY  out  1               MFB word accepted
//  TX_MFB_DATA/SOF_POS/EOF_POS/SOF/EOF  out  as RX_MFB_*   registered copy of accepted word
//  TX_MFB_META     out  REGIONS*META_WIDTH   metadata per region, valid where TX_MFB_SOF(r)=1
//  TX_MFB_SRC_RDY  out  1               output word valid
//  TX_MFB_DST_RDY  in   1               output word accepted
// BEHAVIOUR
//  - Reset (RESET_N=0, async): FIFO empty, wr/rd ptr=0, count=0; TX_MFB_SRC_RDY=0, TX_MFB_SOF/EOF/META=0,
//    RX_MVB_DST_RDY=0, RX_MFB_DST_RDY=0. Mid-frame reset discards FIFO content and the output register.
//  - MVB side: RX_MVB_DST_RDY = registered (FIFO_DEPTH - count >= REGIONS); never depends on RX_MVB_* inputs.
//    On SRC_RDY&DST_RDY, valid items are compacted and written in ascending region order at wr_ptr; wr_ptr += popcount(VLD).
//    Word with VLD=0 accepted, no write. Overflow impossible by construction.
//  - MFB side: nsof = popcount(RX_MFB_SOF). out_free = !TX_MFB_SRC_RDY | TX_MFB_DST_RDY.
//    RX_MFB_DST_RDY = out_free & (count >= nsof) (combinational on SOF, count, TX_MFB_DST_RDY; no path from SRC_RDY).
//    On accept: word registered to TX_MFB_*, region r with SOF gets META = FIFO[rd_ptr + popcount(SOF[r-1:0])],
//    regions without SOF get META=0; rd_ptr += nsof. TX_MFB_SRC_RDY set; cleared when TX_DST_RDY & no new accept.
//  - Words with nsof=0 (frame continuation or idle SOF-less words) pass whenever out_free; never wait on metadata.
//  - Latency: MFB in->out 1 cycle. Metadata written in cycle N is usable by an MFB word accepted in N+1 or later
//    (count is pre-write; no same-cycle bypass).
//  - Simultaneous write+read: count_next = count + popcount(VLD)*mvb_acc - nsof*mfb_acc; ptrs wrap modulo FIFO_DEPTH.
//  - Output held stable while TX_MFB_SRC_RDY=1 & TX_MFB_DST_RDY=0.
//  - Frame ordering between streams is the caller's contract: k-th MVB item belongs to k-th SOF; not checked.
// TESTING
//  1 Reset: RESET_N=0 mid-traffic -> all TX outputs 0, both DST_RDY 0 asynchronously; after release MVB DST_RDY=1 next cycle.
//  2 REGIONS=4, MVB word VLD=0101 meta A,B then MFB word SOF=1010 -> TX META region1=A, region3=B, regions 0,2 = 0.
//  3 MFB SOF=0001 arrives with FIFO empty -> RX_MFB_DST_RDY=0; MVB item C written cycle N -> word accepted N+1, out N+2 META=C.
//  4 Fill FIFO to 13 of 16 -> RX_MVB_DST_RDY=0; one SOF word consumed -> DST_RDY returns next cycle; 64 frames wrap, order kept.
//  5 TX_MFB_DST_RDY random 50%, 1000 frames, random VLD/SOF patterns -> output data identical, META in frame order, no loss/dup.
//  6 SOF-less continuation words with FIFO empty and TX_DST_RDY=1 -> pass every cycle, META=0.

Source files
------------

// File: rtl/tx_mac_lite_meta_merge.sv
// Merges per-frame MVB metadata into an MFB stream, attaching each frame's metadata to its SOF region.
// Latency: MFB in -> out 1 cycle (registered output); metadata is usable one cycle after it is written.
// Backpressure: MVB ready is registered from FIFO headroom; MFB ready needs a free output slot and enough metadata for every SOF.
module tx_mac_lite_meta_merge #(
    parameter int REGIONS     = 4,
    parameter int REGION_SIZE = 8,
    parameter int BLOCK_SIZE  = 8,
    parameter int ITEM_WIDTH  = 8,
    parameter int META_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                                                 CLK,
    input  logic                                                 RESET_N,

    input  logic [REGIONS*META_WIDTH-1:0]                        RX_MVB_DATA,
    input  logic [REGIONS-1:0]                                   RX_MVB_VLD,
    input  logic                                                 RX_MVB_SRC_RDY,
    output logic                                                 RX_MVB_DST_RDY,

    input  logic [REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] RX_MFB_DATA,
    input  logic [REGIONS*$clog2(REGION_SIZE)-1:0]               RX_MFB_SOF_POS,
    input  logic [REGIONS*$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]    RX_MFB_EOF_POS,
    input  logic [REGIONS-1:0]                                   RX_MFB_SOF,
    input  logic [REGIONS-1:0]                                   RX_MFB_EOF,
    input  logic                                                 RX_MFB_SRC_RDY,
    output logic                                                 RX_MFB_DST_RDY,

    output logic [REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] TX_MFB_DATA,
    output logic [REGIONS*META_WIDTH-1:0]                        TX_MFB_META,
    output logic [REGIONS*$clog2(REGION_SIZE)-1:0]               TX_MFB_SOF_POS,
    output logic [REGIONS*$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]    TX_MFB_EOF_POS,
    output logic [REGIONS-1:0]                                   TX_MFB_SOF,
    output logic [REGIONS-1:0]                                   TX_MFB_EOF,
    output logic                                                 TX_MFB_SRC_RDY,
    input  logic                                                 TX_MFB_DST_RDY
);

    localparam int DW = REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH;
    localparam int SW = $clog2(REGION_SIZE);
    localparam int EW = $clog2(REGION_SIZE*BLOCK_SIZE);
    // Pointer width; FIFO_DEPTH >= 2*REGIONS guarantees a popcount of REGIONS fits in AW bits.
    localparam int AW = $clog2(FIFO_DEPTH);
    // Occupancy must represent FIFO_DEPTH itself, hence one extra bit.
    localparam int CW = AW + 1;

    // Metadata storage and bookkeeping
    logic [META_WIDTH-1:0]   r_fifo [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic                    r_mvb_rdy;
    // Held low through reset so MFB ready is also low while RESET_N is asserted.
    logic                    r_active;

    // Output word register
    logic [DW-1:0]           r_tx_data;
    logic [REGIONS*META_WIDTH-1:0] r_tx_meta;
    logic [REGIONS*SW-1:0]   r_tx_sof_pos;
    logic [REGIONS*EW-1:0]   r_tx_eof_pos;
    logic [REGIONS-1:0]      r_tx_sof;
    logic [REGIONS-1:0]      r_tx_eof;
    logic                    r_tx_src_rdy;

    // Combinational helpers
    logic [AW-1:0]           w_nvld;
    logic [AW-1:0]           w_nsof;
    logic [AW-1:0]           w_wr_idx [REGIONS];
    logic [AW-1:0]           w_rd_idx [REGIONS];
    logic [REGIONS*META_WIDTH-1:0] w_meta;
    logic                    w_out_free;
    logic                    w_mfb_rdy;
    logic                    w_mfb_acc;
    logic                    w_mvb_acc;
    logic [CW-1:0]           w_add;
    logic [CW-1:0]           w_sub;
    logic [CW-1:0]           w_count_next;
    logic [CW-1:0]           w_free_next;
    logic                    w_mvb_rdy_next;

    // Running prefix counts give each valid item its compacted write slot and each SOF its read slot.
    always_comb begin
        w_nvld = '0;
        w_nsof = '0;
        for (int r = 0; r < REGIONS; r++) begin
            w_wr_idx[r] = r_wr_ptr + w_nvld;
            w_rd_idx[r] = r_rd_ptr + w_nsof;
            w_nvld      = w_nvld + AW'(RX_MVB_VLD[r]);
            w_nsof      = w_nsof + AW'(RX_MFB_SOF[r]);
        end
    end

    // Pick metadata for each SOF region; regions without SOF carry zero.
    always_comb begin
        w_meta = '0;
        for (int r = 0; r < REGIONS; r++) begin
            if (RX_MFB_SOF[r]) begin
                w_meta[r*META_WIDTH +: META_WIDTH] = r_fifo[w_rd_idx[r]];
            end
        end
    end

    // MFB ready never looks at RX_MFB_SRC_RDY; occupancy is the pre-write value, so there is no bypass.
    assign w_out_free     = ~r_tx_src_rdy | TX_MFB_DST_RDY;
    assign w_mfb_rdy      = r_active & w_out_free & (r_count >= {1'b0, w_nsof});
    assign w_mfb_acc      = RX_MFB_SRC_RDY & w_mfb_rdy;
    assign w_mvb_acc      = RX_MVB_SRC_RDY & r_mvb_rdy;

    assign w_add          = w_mvb_acc ? {1'b0, w_nvld} : '0;
    assign w_sub          = w_mfb_acc ? {1'b0, w_nsof} : '0;
    assign w_count_next   = r_count + w_add - w_sub;
    // Ready is derived from next occupancy so a full word can never overflow the FIFO.
    assign w_free_next    = CW'(FIFO_DEPTH) - w_count_next;
    assign w_mvb_rdy_next = (w_free_next >= CW'(REGIONS));

    // Compacted metadata write; storage needs no reset since occupancy governs validity.
    always_ff @(posedge CLK) begin
        if (w_mvb_acc) begin
            for (int r = 0; r < REGIONS; r++) begin
                if (RX_MVB_VLD[r]) begin
                    r_fifo[w_wr_idx[r]] <= RX_MVB_DATA[r*META_WIDTH +: META_WIDTH];
                end
            end
        end
    end

    // FIFO pointers, occupancy and the registered MVB ready.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_mvb_rdy <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_active  <= 1'b1;
            r_mvb_rdy <= w_mvb_rdy_next;
            r_count   <= w_count_next;
            if (w_mvb_acc) begin
                r_wr_ptr <= r_wr_ptr + w_nvld;
            end
            if (w_mfb_acc) begin
                r_rd_ptr <= r_rd_ptr + w_nsof;
            end
        end
    end

    // Output register: load on accept, drop valid once the sink takes it and nothing new arrives.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tx_data    <= '0;
            r_tx_meta    <= '0;
            r_tx_sof_pos <= '0;
            r_tx_eof_pos <= '0;
            r_tx_sof     <= '0;
            r_tx_eof     <= '0;
            r_tx_src_rdy <= 1'b0;
        end else if (w_mfb_acc) begin
            r_tx_data    <= RX_MFB_DATA;
            r_tx_meta    <= w_meta;
            r_tx_sof_pos <= RX_MFB_SOF_POS;
            r_tx_eof_pos <= RX_MFB_EOF_POS;
            r_tx_sof     <= RX_MFB_SOF;
            r_tx_eof     <= RX_MFB_EOF;
            r_tx_src_rdy <= 1'b1;
        end else if (TX_MFB_DST_RDY) begin
            r_tx_src_rdy <= 1'b0;
        end
    end

    assign RX_MVB_DST_RDY = r_mvb_rdy;
    assign RX_MFB_DST_RDY = w_mfb_rdy;
    assign TX_MFB_DATA    = r_tx_data;
    assign TX_MFB_META    = r_tx_meta;
    assign TX_MFB_SOF_POS = r_tx_sof_pos;
    assign TX_MFB_EOF_POS = r_tx_eof_pos;
    assign TX_MFB_SOF     = r_tx_sof;
    assign TX_MFB_EOF     = r_tx_eof;
    assign TX_MFB_SRC_RDY = r_tx_src_rdy;

endmodule
